instruction_fetch: RTL and testbench

Fetch stage directly downstream of the program counter. It samples the current PC and issues a single-outstanding 32-bit instruction read to instruction memory over a req/ack handshake. It holds the returned word in an instruction register for the decode stage under a valid/ready handshake, and pulses `pc_load` so the PC advances once per completed fetch. Misaligned PCs and memory timeouts raise a sticky fault. Both faults are cleared only by `flush` or reset.

---
 rtl/instruction_fetch_if.sv | 30 +++
 rtl/instruction_fetch.sv | 121 ++++++++++++
 tb/tb_instruction_fetch.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// Instruction memory read bus between the fetch stage and instruction memory.
// Carries one single-outstanding 32-bit read per req/ack handshake.
//   mem_req   : read request, held high until acknowledged (fetch -> memory)
//   mem_addr  : read address, stable while mem_req is high (fetch -> memory)
//   mem_ack   : response strobe, mem_rdata valid in the same cycle (memory -> fetch)
//   mem_rdata : instruction word (memory -> fetch)
// Modports: master = fetch stage, slave = instruction memory.
interface instruction_fetch_if #(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned INSTR_W = 32
) ();
    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_ack;
    logic [INSTR_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage downstream of the program counter. Samples PC_in in IDLE, issues one
// instruction read over the mem bus, holds the word in IR for decode under a
// valid/ready handshake and pulses pc_load once per completed fetch. Misaligned PCs
// and memory timeouts raise a sticky fault cleared only by flush or reset.
// Ports:
//   clock, reset        : rising-edge clock, asynchronous active-low reset
//   enable              : permits a new fetch to start from IDLE
//   flush               : synchronous abort back to IDLE, clears IR valid and fault
//   PC_in               : current PC, sampled only in IDLE
//   pc_load             : one-cycle pulse after each completed fetch
//   mem                 : instruction memory bus (master side)
//   IR, IR_PC, ir_valid : instruction register, its address and valid flag
//   decode_ready        : decode accepts IR when high with ir_valid
//   fault, fault_code   : sticky fault, 00 none / 01 misaligned / 10 timeout
module instruction_fetch #(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      flush,
    input  logic [ADDR_W-1:0]         PC_in,
    output logic                      pc_load,
    instruction_fetch_if.master       mem,
    output logic [INSTR_W-1:0]        IR,
    output logic [ADDR_W-1:0]         IR_PC,
    output logic                      ir_valid,
    input  logic                      decode_ready,
    output logic                      fault,
    output logic [1:0]                fault_code
);

    localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StReq, StFull, StFault} state_e;

    state_e              state;
    logic [CntW-1:0]     cnt;
    logic                mem_req;
    logic [ADDR_W-1:0]   mem_addr;

    assign mem.mem_req  = mem_req;
    assign mem.mem_addr = mem_addr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= StIdle;
            cnt        <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            IR         <= '0;
            IR_PC      <= '0;
            ir_valid   <= 1'b0;
            pc_load    <= 1'b0;
            fault      <= 1'b0;
            fault_code <= 2'b00;
        end else begin
            // pc_load is a single-cycle pulse; only the ack transition raises it.
            pc_load <= 1'b0;
            if (flush) begin
                // Flush wins over ack, timeout, accept and enable; a colliding
                // ack's word is dropped.
                state      <= StIdle;
                cnt        <= '0;
                mem_req    <= 1'b0;
                ir_valid   <= 1'b0;
                fault      <= 1'b0;
                fault_code <= 2'b00;
            end else begin
                unique case (state)
                    StIdle: begin
                        if (enable) begin
                            if (PC_in[1:0] == 2'b00) begin
                                mem_addr <= PC_in;
                                mem_req  <= 1'b1;
                                cnt      <= '0;
                                state    <= StReq;
                            end else begin
                                fault      <= 1'b1;
                                fault_code <= 2'b01;
                                state      <= StFault;
                            end
                        end
                    end
                    StReq: begin
                        cnt <= cnt + 1'b1;
                        // Ack is checked first so an ack in the last allowed
                        // request cycle is still taken.
                        if (mem.mem_ack) begin
                            IR       <= mem.mem_rdata;
                            IR_PC    <= mem_addr;
                            ir_valid <= 1'b1;
                            mem_req  <= 1'b0;
                            pc_load  <= 1'b1;
                            state    <= StFull;
                        end else if (cnt == CntLast) begin
                            mem_req    <= 1'b0;
                            fault      <= 1'b1;
                            fault_code <= 2'b10;
                            state      <= StFault;
                        end
                    end
                    StFull: begin
                        if (ir_valid && decode_ready) begin
                            ir_valid <= 1'b0;
                            state    <= StIdle;
                        end
                    end
                    StFault: begin
                        // Held until flush or reset.
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned TIMEOUT = 16;

    logic               clock = 1'b0;
    logic               reset;
    logic               enable;
    logic               flush;
    logic [ADDR_W-1:0]  PC_in;
    logic               pc_load;
    logic [INSTR_W-1:0] IR;
    logic [ADDR_W-1:0]  IR_PC;
    logic               ir_valid;
    logic               decode_ready;
    logic               fault;
    logic [1:0]         fault_code;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    instruction_fetch_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

    instruction_fetch #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .TIMEOUT(TIMEOUT)) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .flush        (flush),
        .PC_in        (PC_in),
        .pc_load      (pc_load),
        .mem          (bus.master),
        .IR           (IR),
        .IR_PC        (IR_PC),
        .ir_valid     (ir_valid),
        .decode_ready (decode_ready),
        .fault        (fault),
        .fault_code   (fault_code)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Bounded wait for a request to appear.
    task automatic wait_req(input string tag, input int budget);
        int n = 0;
        while (bus.mem_req !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 64'(bus.mem_req), 64'd1);
    endtask

    initial begin
        logic [ADDR_W-1:0]  exp_pc;
        logic [INSTR_W-1:0] held;
        logic [INSTR_W-1:0] word;
        int last_req;
        int n;
        int lat;
        int stall;
        int gap;

        reset = 1'b0; enable = 1'b0; flush = 1'b0; PC_in = '0; decode_ready = 1'b0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        tick(); tick();
        chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
        chk("rst_mem_addr", bus.mem_addr, 64'd0);
        chk("rst_ir", 64'(IR), 64'd0);
        chk("rst_ir_pc", IR_PC, 64'd0);
        chk("rst_ir_valid", 64'(ir_valid), 64'd0);
        chk("rst_pc_load", 64'(pc_load), 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);
        chk("rst_fault_code", 64'(fault_code), 64'd0);
        reset = 1'b1;
        tick();

        // Zero-wait stream: one fetch every 3 cycles.
        exp_pc = '0; PC_in = '0; enable = 1'b1; decode_ready = 1'b1; last_req = 0;
        for (int f = 0; f < 3; f++) begin
            wait_req("zw_req", 10);
            if (f > 0) chk("zw_period", 64'(cyc - last_req), 64'd3);
            last_req = cyc;
            chk("zw_addr", bus.mem_addr, exp_pc);
            bus.mem_ack = 1'b1; bus.mem_rdata = 32'h8B00_0000 + exp_pc[31:0];
            tick();
            bus.mem_ack = 1'b0;
            chk("zw_ir", 64'(IR), 64'(32'h8B00_0000 + exp_pc[31:0]));
            chk("zw_ir_pc", IR_PC, exp_pc);
            chk("zw_pc_load", 64'(pc_load), 64'd1);
            if (pc_load) PC_in = PC_in + 64'd4;
            exp_pc = exp_pc + 64'd4;
            if (f == 2) enable = 1'b0;
            tick();
            chk("zw_pc_load_once", 64'(pc_load), 64'd0);
            chk("zw_accepted", 64'(ir_valid), 64'd0);
        end

        // Backpressure.
        flush = 1'b1; tick(); flush = 1'b0;
        PC_in = '0; decode_ready = 1'b0; enable = 1'b1;
        wait_req("bp_req", 10);
        chk("bp_addr0", bus.mem_addr, 64'd0);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1234_5678;
        tick();
        bus.mem_ack = 1'b0;
        held = 32'h1234_5678;
        chk("bp_pc_load", 64'(pc_load), 64'd1);
        PC_in = 64'd4;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 64'(ir_valid), 64'd1);
            chk("bp_ir", 64'(IR), 64'(held));
            chk("bp_no_req", 64'(bus.mem_req), 64'd0);
            chk("bp_no_pc_load", 64'(pc_load), 64'd0);
        end
        decode_ready = 1'b1;
        tick();
        wait_req("bp_req2", 10);
        chk("bp_addr1", bus.mem_addr, 64'd4);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0;
        tick();
        bus.mem_ack = 1'b0; enable = 1'b0;
        tick();

        // Misaligned PC.
        PC_in = 64'h6; enable = 1'b1;
        tick();
        chk("mis_req", 64'(bus.mem_req), 64'd0);
        chk("mis_fault", 64'(fault), 64'd1);
        chk("mis_code", 64'(fault_code), 64'd1);
        tick(); tick(); tick();
        chk("mis_req_held", 64'(bus.mem_req), 64'd0);
        chk("mis_code_held", 64'(fault_code), 64'd1);
        flush = 1'b1; PC_in = 64'h8;
        tick();
        flush = 1'b0;
        chk("mis_flush_fault", 64'(fault), 64'd0);
        chk("mis_flush_code", 64'(fault_code), 64'd0);
        wait_req("mis_resume", 10);
        chk("mis_resume_addr", bus.mem_addr, 64'h8);

        // Timeout: no ack for this request.
        n = 1;
        while (bus.mem_req === 1'b1 && n < 40) begin
            tick();
            if (bus.mem_req === 1'b1) n++;
        end
        chk("to_req_cycles", 64'(n), 64'(TIMEOUT));
        chk("to_fault", 64'(fault), 64'd1);
        chk("to_code", 64'(fault_code), 64'd2);
        enable = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
        tick();
        bus.mem_ack = 1'b0;
        tick();
        chk("to_late_valid", 64'(ir_valid), 64'd0);
        chk("to_late_pc_load", 64'(pc_load), 64'd0);
        chk("to_late_code", 64'(fault_code), 64'd2);
        chk("to_late_req", 64'(bus.mem_req), 64'd0);
        flush = 1'b1; PC_in = 64'h10;
        tick();
        flush = 1'b0;

        // Ack in the last permitted request cycle.
        enable = 1'b1;
        wait_req("bd_req", 10);
        chk("bd_addr", bus.mem_addr, 64'h10);
        for (int i = 1; i < TIMEOUT; i++) tick();
        chk("bd_req_still", 64'(bus.mem_req), 64'd1);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hD503_201F;
        tick();
        bus.mem_ack = 1'b0; enable = 1'b0;
        chk("bd_ir", 64'(IR), 64'hD503_201F);
        chk("bd_ir_pc", IR_PC, 64'h10);
        chk("bd_valid", 64'(ir_valid), 64'd1);
        chk("bd_fault", 64'(fault), 64'd0);
        chk("bd_code", 64'(fault_code), 64'd0);
        tick();

        // Flush colliding with ack.
        PC_in = 64'h20; enable = 1'b1;
        wait_req("fc_req", 10);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFE_F00D; flush = 1'b1; enable = 1'b0;
        tick();
        bus.mem_ack = 1'b0; flush = 1'b0;
        chk("fc_valid", 64'(ir_valid), 64'd0);
        chk("fc_pc_load", 64'(pc_load), 64'd0);
        chk("fc_req", 64'(bus.mem_req), 64'd0);
        enable = 1'b1;
        tick();
        chk("fc_idle_req", 64'(bus.mem_req), 64'd1);
        chk("fc_idle_addr", bus.mem_addr, 64'h20);

        // Asynchronous reset mid-request.
        #3;
        reset = 1'b0;
        #1;
        chk("ar_req", 64'(bus.mem_req), 64'd0);
        chk("ar_addr", bus.mem_addr, 64'd0);
        #2;
        reset = 1'b1; enable = 1'b0;
        tick();

        // Randomized fetch stream against a PC/word-list model.
        exp_pc = 64'h100; PC_in = exp_pc; decode_ready = 1'b0; enable = 1'b1;
        for (int f = 0; f < 40; f++) begin
            wait_req("rnd_req", 20);
            chk("rnd_addr", bus.mem_addr, exp_pc);
            lat = $urandom_range(0, 8);
            for (int i = 0; i < lat; i++) begin
                tick();
                chk("rnd_req_hold", 64'(bus.mem_req), 64'd1);
                chk("rnd_addr_hold", bus.mem_addr, exp_pc);
            end
            word = $urandom;
            stall = $urandom_range(0, 3);
            decode_ready = 1'b0;
            bus.mem_ack = 1'b1; bus.mem_rdata = word;
            tick();
            bus.mem_ack = 1'b0;
            chk("rnd_pc_load", 64'(pc_load), 64'd1);
            chk("rnd_ir", 64'(IR), 64'(word));
            chk("rnd_ir_pc", IR_PC, exp_pc);
            if (pc_load) PC_in = PC_in + 64'd4;
            exp_pc = exp_pc + 64'd4;
            for (int s = 0; s < stall; s++) begin
                tick();
                chk("rnd_stall_valid", 64'(ir_valid), 64'd1);
                chk("rnd_stall_pc_load", 64'(pc_load), 64'd0);
            end
            decode_ready = 1'b1;
            tick();
            chk("rnd_accept", 64'(ir_valid), 64'd0);
            chk("rnd_ir_kept", 64'(IR), 64'(word));
            gap = $urandom_range(0, 2);
            enable = (gap == 0);
            for (int g = 0; g < gap; g++) begin
                tick();
                chk("rnd_gap_no_req", 64'(bus.mem_req), 64'd0);
            end
            enable = 1'b1;
        end
        chk("rnd_fault_none", 64'(fault), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
